// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered, handshaked ALU with an iterative shift-add multiplier.
//
// Operations are taken over a valid/ready input handshake. Single-cycle ops are
// computed combinationally and registered on the accepting edge. MUL latches its
// operands, runs one shift-add step per cycle for WIDTH cycles, then registers
// the product on the following edge. The result and flags are held in output
// registers until consumed over the valid/ready output handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand/opcode valid          in_ready   can accept this cycle
//   a, b       operands (WIDTH)              cin        carry-in / borrow-in
//   alu_sel    opcode (OP_W)
//   out_valid  unconsumed result held        out_ready  consumer accepts result
//   alu_out    registered result             alu_cout   carry/no-borrow/mul-ovf
//   overflow   signed overflow               zero       alu_out == 0
//   negative   alu_out MSB                   op_err     reserved opcode executed
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 4,
   parameter int OP_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [OP_W-1:0]  alu_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             alu_cout,
   output logic             overflow,
   output logic             zero,
   output logic             negative,
   output logic             op_err
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_NOT  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_AND  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(4);
   localparam logic [OP_W-1:0] OP_XOR  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_EQ   = OP_W'(7);
   localparam logic [OP_W-1:0] OP_SLTU = OP_W'(8);
   localparam logic [OP_W-1:0] OP_MUL  = OP_W'(9);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                r_state;
   logic [WIDTH-1:0]      r_alu_out;
   logic                  r_cout;
   logic                  r_ovf;
   logic                  r_err;
   logic [2*WIDTH-1:0]    r_acc;
   logic [2*WIDTH-1:0]    r_mcand;
   logic [WIDTH-1:0]      r_mplier;
   logic [CNT_W-1:0]      r_cnt;

   logic                  w_accept;
   logic                  w_is_mul;
   logic [WIDTH:0]        w_sum;
   logic [WIDTH:0]        w_diff;
   logic signed [WIDTH-1:0] w_sa;
   logic signed [WIDTH-1:0] w_sb;
   logic [WIDTH-1:0]      w_res;
   logic                  w_cout;
   logic                  w_ovf;
   logic                  w_err;
   logic [2*WIDTH-1:0]    w_acc_step;

   assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
   assign out_valid = (r_state == S_DONE);
   assign w_accept  = in_valid && in_ready;
   assign w_is_mul  = (alu_sel == OP_MUL);

   assign alu_out  = r_alu_out;
   assign alu_cout = r_cout;
   assign overflow = r_ovf;
   assign op_err   = r_err;
   assign zero     = (r_alu_out == '0);
   assign negative = r_alu_out[WIDTH-1];

   // Extra top bit: carry for ADD, borrow for SUB (set when a < b+cin).
   assign w_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign w_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
   assign w_sa   = a;
   assign w_sb   = b;

   assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);

   always_comb begin
      w_res  = '0;
      w_cout = 1'b0;
      w_ovf  = 1'b0;
      w_err  = 1'b0;
      case (alu_sel)
         OP_ADD: begin
            w_res  = w_sum[WIDTH-1:0];
            w_cout = w_sum[WIDTH];
            w_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_res  = w_diff[WIDTH-1:0];
            w_cout = ~w_diff[WIDTH];
            w_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_NOT:  w_res = ~a;
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_XOR:  w_res = a ^ b;
         OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, (w_sa < w_sb)};
         OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (a == b)};
         OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_MUL:  w_res = '0;   // produced by the iterative path
         default: w_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_alu_out <= '0;
         r_cout    <= 1'b0;
         r_ovf     <= 1'b0;
         r_err     <= 1'b0;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  if (w_is_mul) begin
                     r_state  <= S_BUSY;
                     r_mcand  <= {{WIDTH{1'b0}}, a};
                     r_mplier <= b;
                     r_acc    <= '0;
                     r_cnt    <= '0;
                  end else begin
                     r_state   <= S_DONE;
                     r_alu_out <= w_res;
                     r_cout    <= w_cout;
                     r_ovf     <= w_ovf;
                     r_err     <= w_err;
                  end
               end else if ((r_state == S_DONE) && out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            S_BUSY: begin
               // WIDTH accumulate steps, then one edge to register the product.
               if (r_cnt == CNT_W'(WIDTH)) begin
                  r_state   <= S_DONE;
                  r_alu_out <= r_acc[WIDTH-1:0];
                  r_cout    <= |r_acc[2*WIDTH-1:WIDTH];
                  r_ovf     <= 1'b0;
                  r_err     <= 1'b0;
               end else begin
                  r_acc    <= w_acc_step;
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_cnt    <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq (WIDTH=4).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, i.e. just after the edge that registered them.
// -----------------------------------------------------------------------------
module tb_alu_seq;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [3:0]   alu_sel;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] alu_out;
   logic         alu_cout;
   logic         overflow;
   logic         zero;
   logic         negative;
   logic         op_err;

   int n_cmp = 0;
   int n_bad = 0;

   alu_seq #(.WIDTH(W), .OP_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .alu_sel(alu_sel),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_out(alu_out), .alu_cout(alu_cout), .overflow(overflow),
      .zero(zero), .negative(negative), .op_err(op_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no $finish, required end of test");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one single-cycle op for exactly one edge.
   task automatic op(input logic [3:0] sel, input logic [W-1:0] av,
                     input logic [W-1:0] bv, input logic c);
      alu_sel  = sel;
      a        = av;
      b        = bv;
      cin      = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic flags(input string tag, input int r, input int co, input int ov,
                        input int z, input int ng, input int er);
      check({tag, ".out"},  32'(alu_out),  32'(r));
      check({tag, ".cout"}, 32'(alu_cout), 32'(co));
      check({tag, ".ovf"},  32'(overflow), 32'(ov));
      check({tag, ".zero"}, 32'(zero),     32'(z));
      check({tag, ".neg"},  32'(negative), 32'(ng));
      check({tag, ".err"},  32'(op_err),   32'(er));
      check({tag, ".vld"},  32'(out_valid), 32'd1);
   endtask

   // MUL: count edges from accept to out_valid, garbage on inputs while busy.
   task automatic mul(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input int r, input int co);
      int n;
      op(4'd9, av, bv, 1'b0);
      check({tag, ".rdy_busy"}, 32'(in_ready), 32'd0);
      n = 0;
      in_valid = 1'b1;
      alu_sel  = 4'd0;
      while (!out_valid && n < 12) begin
         a = ~a;
         b = b + 4'd1;
         tick();
         n++;
         if (!out_valid) check({tag, ".rdy_busy"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      check({tag, ".lat"}, 32'(n), 32'd5);
      flags(tag, r, co, 0, (r == 0) ? 1 : 0, (r >= 8) ? 1 : 0, 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; alu_sel = '0;
      tick(); tick();
      check("rst.vld",  32'(out_valid), 32'd0);
      check("rst.out",  32'(alu_out),   32'd0);
      check("rst.zero", 32'(zero),      32'd1);
      check("rst.cout", 32'(alu_cout),  32'd0);
      check("rst.ovf",  32'(overflow),  32'd0);
      check("rst.neg",  32'(negative),  32'd0);
      check("rst.err",  32'(op_err),    32'd0);
      check("rst.rdy",  32'(in_ready),  32'd1);
      rst_n = 1'b1;
      tick();

      // Arithmetic, issued back to back.
      op(4'd0, 4'd7, 4'd1, 1'b0);   flags("add7_1", 8, 0, 1, 0, 1, 0);
      op(4'd0, 4'd15, 4'd1, 1'b0);  flags("add15_1", 0, 1, 0, 1, 0, 0);
      op(4'd0, 4'd7, 4'd8, 1'b1);   flags("add_cin", 0, 1, 0, 1, 0, 0);
      op(4'd1, 4'd3, 4'd5, 1'b0);   flags("sub3_5", 14, 0, 0, 0, 1, 0);
      op(4'd1, 4'd8, 4'd1, 1'b0);   flags("sub8_1", 7, 1, 1, 0, 0, 0);
      op(4'd1, 4'd5, 4'd5, 1'b1);   flags("sub_bin", 15, 0, 0, 0, 1, 0);
      op(4'd6, 4'd8, 4'd1, 1'b0);   flags("slt", 1, 0, 0, 0, 0, 0);
      op(4'd8, 4'd8, 4'd1, 1'b0);   flags("sltu", 0, 0, 0, 1, 0, 0);
      op(4'd0, 4'd15, 4'd1, 1'b0);  // leave cout=1 to see logic ops clear it
      op(4'd2, 4'd5, 4'd0, 1'b1);   flags("not", 10, 0, 0, 0, 1, 0);
      op(4'd3, 4'd12, 4'd10, 1'b0); flags("and", 8, 0, 0, 0, 1, 0);
      op(4'd4, 4'd12, 4'd10, 1'b0); flags("or", 14, 0, 0, 0, 1, 0);
      op(4'd5, 4'd12, 4'd10, 1'b0); flags("xor", 6, 0, 0, 0, 0, 0);
      tick();
      check("idle.vld", 32'(out_valid), 32'd0);

      mul("mul5_3", 4'd5, 4'd3, 15, 0);
      mul("mul15_15", 4'd15, 4'd15, 1, 1);
      tick();

      // Backpressure: hold a result while inputs toggle.
      out_ready = 1'b0;
      op(4'd0, 4'd2, 4'd3, 1'b0);
      flags("bp0", 5, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         alu_sel  = 4'(i + 1);
         a        = 4'(i * 5 + 3);
         b        = 4'(i + 9);
         tick();
         check("bp.out", 32'(alu_out),   32'd5);
         check("bp.vld", 32'(out_valid), 32'd1);
         check("bp.rdy", 32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      alu_sel = 4'd5; a = 4'd12; b = 4'd10; cin = 1'b0;
      #1;
      check("bp.rdy_up", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      flags("bp_next", 6, 0, 0, 0, 0, 0);

      // Reset during BUSY cycle 2.
      op(4'd9, 4'd5, 4'd3, 1'b0);
      tick(); tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("amid.vld",  32'(out_valid), 32'd0);
      check("amid.out",  32'(alu_out),   32'd0);
      check("amid.zero", 32'(zero),      32'd1);
      #2;
      rst_n = 1'b1;
      tick();
      check("arst.rdy", 32'(in_ready), 32'd1);
      check("arst.vld", 32'(out_valid), 32'd0);
      op(4'd0, 4'd2, 4'd2, 1'b0);   flags("add2_2", 4, 0, 0, 0, 0, 0);

      // Reserved opcodes and recovery.
      op(4'd0, 4'd15, 4'd2, 1'b0);  // nonzero, cout=1 beforehand
      op(4'd12, 4'd7, 4'd7, 1'b1);  flags("rsv12", 0, 0, 0, 1, 0, 1);
      op(4'd7, 4'd9, 4'd9, 1'b0);   flags("eq9_9", 1, 0, 0, 0, 0, 0);
      op(4'd15, 4'd9, 4'd3, 1'b0);  flags("rsv15", 0, 0, 0, 1, 0, 1);
      op(4'd7, 4'd9, 4'd8, 1'b0);   flags("eq9_8", 0, 0, 0, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
